up_counter_mod: RTL

- Parameterised up-counter with programmable terminal value and synchronous load.
- Two modes: free-running wrap, and one-shot (count to limit, then halt).
- Provides a registered wrap pulse, a sticky done flag and a saturating wrap tally.
- Counts in the opposite direction to the team's existing 4-bit down counter; used for timers, tick generators and sequence indices.

---
 rtl/up_counter_mod_if.sv | 27 ++
 rtl/up_counter_mod.sv | 84 ++++++++
 2 files changed

// File: rtl/up_counter_mod_if.sv
// Control and status bundle for up_counter_mod: the master drives count controls,
// the slave (the counter) returns count, wrap pulse, done flag and wrap tally.
interface up_counter_mod_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              en;
  logic              mode;
  logic [WIDTH-1:0]  limit;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_tally;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output en, mode, limit, load, load_val, clr_tally,
    input  count, wrap, done, wrap_cnt
  );

  modport slave (
    input  en, mode, limit, load, load_val, clr_tally,
    output count, wrap, done, wrap_cnt
  );
endinterface

// File: rtl/up_counter_mod.sv
// Up-counter with programmable terminal value, wrap or one-shot mode, load,
// registered wrap pulse, sticky done and a saturating wrap tally.
module up_counter_mod #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  up_counter_mod_if.slave bus
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [WRAP_W-1:0] TALLY_MAX = {WRAP_W{1'b1}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic               term;
  logic               step;

  // >= so a limit lowered beneath the current count still terminates
  assign term = (count_q >= bus.limit);
  assign step = (state_q == RUN) && bus.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = RUN;
    end else if (step && term && bus.mode) begin
      state_d = HALT;
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (step) begin
      if (!term) begin
        count_d = count_q + WIDTH'(1);
      end else if (!bus.mode) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end
    end
    if (bus.clr_tally) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && (wrap_cnt_q != TALLY_MAX)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  always_comb begin
    bus.count    = count_q;
    bus.wrap     = wrap_q;
    bus.done     = (state_q == HALT);
    bus.wrap_cnt = wrap_cnt_q;
  end

endmodule
